// File: rtl/grid_pkg.sv
// Shared definitions for the 12x12 ship grid: cell status encoding,
// grid geometry and the cell update rule used by the writer.
package grid_pkg;

    // 2-bit status stored per grid cell
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_status_t;

    localparam int GRID_ROWS           = 12;
    localparam int GRID_COLUMNS        = 12;
    localparam int GRID_ELEMENT_WIDTH  = 32;
    localparam int GRID_ELEMENT_HEIGHT = 32;
    localparam int GRID_BORDER_WIDTH   = 2;
    localparam int GRID_CELLS          = GRID_ROWS * GRID_COLUMNS;

    // Writer FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_MODIFY = 3'd2,
        S_DONE   = 3'd3,
        S_CLEAR  = 3'd4
    } writer_state_t;

    // New cell status after a click.
    // Placement toggles EMPTY/SHIP; attack turns SHIP into HIT and
    // EMPTY into MISS. Already-resolved cells (HIT/MISS) never change.
    function automatic cell_status_t next_status(input cell_status_t cur,
                                                 input logic         attack);
        cell_status_t res;
        res = cur;
        if (!attack) begin
            case (cur)
                EMPTY:   res = SHIP;
                SHIP:    res = EMPTY;
                default: res = cur;
            endcase
        end else begin
            case (cur)
                SHIP:    res = HIT;
                EMPTY:   res = MISS;
                default: res = cur;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/grid_pos_decoder.sv
// Combinational screen position -> grid cell decoder.
// A position counts only if it falls inside a cell's interior, i.e. not
// on the 2 px border at the top/left of each 32 px cell.
module grid_pos_decoder
    import grid_pkg::*;
#(
    parameter int X_POS = 0,
    parameter int Y_POS = 0
) (
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic        o_in_grid,
    output logic [7:0]  o_addr
);

    logic signed [12:0] w_dx;
    logic signed [12:0] w_dy;
    logic [4:0]         w_col;
    logic [4:0]         w_row;
    logic               w_x_ok;
    logic               w_y_ok;

    assign w_dx  = $signed({1'b0, i_x}) - 13'(X_POS);
    assign w_dy  = $signed({1'b0, i_y}) - 13'(Y_POS);
    assign w_col = w_dx[9:5];
    assign w_row = w_dy[9:5];

    // Non-negative offset, below 1024 px (so col/row are the full quotient),
    // inside the 12 columns/rows and past the cell border.
    assign w_x_ok = !w_dx[12] && (w_dx[11:10] == 2'b00)
                 && (w_col < 5'(GRID_COLUMNS))
                 && (w_dx[4:0] >= 5'(GRID_BORDER_WIDTH));
    assign w_y_ok = !w_dy[12] && (w_dy[11:10] == 2'b00)
                 && (w_row < 5'(GRID_ROWS))
                 && (w_dy[4:0] >= 5'(GRID_BORDER_WIDTH));

    assign o_in_grid = w_x_ok && w_y_ok;
    assign o_addr    = 8'(w_row) * 8'(GRID_COLUMNS) + 8'(w_col);

endmodule

// File: rtl/grid_cell_writer.sv
// Write-side controller of the ship grid RAM: read-modify-write of one
// cell per accepted click, plus a full sweep that clears all 144 cells.
// Timeline of a click accepted at edge N (all outputs registered):
//   N   : rd_addr, busy=1        (RAM samples rd_addr at N+1)
//   N+2 : wr_en/wr_addr/wr_data, result (rd_data valid during MODIFY)
//   N+3 : done pulse
//   N+4 : busy=0, a new click can be taken at this edge
module grid_cell_writer
    import grid_pkg::*;
#(
    parameter int X_POS = 0,
    parameter int Y_POS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        click,
    input  logic        mode,
    input  logic        clear_req,
    output logic [7:0]  rd_addr,
    input  logic [1:0]  rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [1:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result
);

    writer_state_t r_state;
    writer_state_t w_state_next;

    logic [7:0]   r_cell_addr;
    logic         r_mode;
    logic [7:0]   r_clr_cnt;

    logic         w_in_grid;
    logic [7:0]   w_dec_addr;
    cell_status_t w_new_status;

    logic [7:0]   r_rd_addr,  w_rd_addr_next;
    logic         r_wr_en,    w_wr_en_next;
    logic [7:0]   r_wr_addr,  w_wr_addr_next;
    logic [1:0]   r_wr_data,  w_wr_data_next;
    logic         r_busy,     w_busy_next;
    logic         r_done,     w_done_next;
    logic [1:0]   r_result,   w_result_next;

    grid_pos_decoder #(
        .X_POS (X_POS),
        .Y_POS (Y_POS)
    ) u_pos_decoder (
        .i_x       (mouse_xpos),
        .i_y       (mouse_ypos),
        .o_in_grid (w_in_grid),
        .o_addr    (w_dec_addr)
    );

    assign w_new_status = next_status(cell_status_t'(rd_data), r_mode);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an in-grid click wins over a simultaneous clear
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (click && w_in_grid) begin
                    w_state_next = S_READ;
                end else if (clear_req) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_READ:   w_state_next = S_MODIFY;
            S_MODIFY: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            S_CLEAR: begin
                if (r_clr_cnt == 8'(GRID_CELLS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Capture the clicked cell/mode and run the clear address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cell_addr <= 8'd0;
            r_mode      <= 1'b0;
            r_clr_cnt   <= 8'd0;
        end else begin
            if (r_state == S_IDLE && w_state_next == S_READ) begin
                r_cell_addr <= w_dec_addr;
                r_mode      <= mode;
            end
            if (r_state == S_IDLE) begin
                r_clr_cnt <= 8'd0;
            end else if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 8'd1;
            end
        end
    end

    // Output next values; address/data/result hold between operations
    always_comb begin
        w_rd_addr_next = r_rd_addr;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_result_next  = r_result;
        w_done_next    = (r_state == S_DONE);
        // busy spans the whole operation including the cycle the done
        // pulse is visible, so it drops one edge after returning to IDLE
        w_busy_next    = (r_state != S_IDLE) || (w_state_next != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_state_next == S_READ) begin
                    w_rd_addr_next = w_dec_addr;
                end
            end
            S_MODIFY: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_cell_addr;
                w_wr_data_next = w_new_status;
                w_result_next  = w_new_status;
            end
            S_CLEAR: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_clr_cnt;
                w_wr_data_next = EMPTY;
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= 8'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 2'b00;
        end else begin
            r_rd_addr <= w_rd_addr_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_result  <= w_result_next;
        end
    end

    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;

endmodule

// File: tb/tb_grid_cell_writer.sv
// Self-checking bench for grid_cell_writer: a grid RAM model with 1-cycle
// read latency, a timeline-based behavioural model, a per-cycle compare
// process and directed scenarios with literal expectations.
module tb_grid_cell_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        click, mode, clear_req;
    logic [7:0]  rd_addr, wr_addr;
    logic [1:0]  rd_data, wr_data, result;
    logic        wr_en, busy, done;

    logic [7:0]  d2_rd_addr, d2_wr_addr;
    logic [1:0]  d2_wr_data, d2_result;
    logic        d2_wr_en, d2_busy, d2_done;

    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [1:0]  pre_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grid_cell_writer #(.X_POS(0), .Y_POS(0)) dut (
        .clk(clk), .rst_n(rst_n), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .click(click), .mode(mode), .clear_req(clear_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .result(result)
    );

    grid_cell_writer #(.X_POS(10), .Y_POS(0)) dut_off (
        .clk(clk), .rst_n(rst_n), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .click(click), .mode(mode), .clear_req(clear_req), .rd_addr(d2_rd_addr),
        .rd_data(2'b00), .wr_en(d2_wr_en), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
        .busy(d2_busy), .done(d2_done), .result(d2_result)
    );

    // Grid RAM: synchronous write, registered read, preload port for the bench
    logic [1:0] ram [0:255] = '{default: 2'b00};
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        if (pre_en) ram[pre_addr] <= pre_val;
        rd_data <= ram[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_grid [0:143] = '{default: 2'b00};
    logic [7:0] e_rd_addr, e_wr_addr;
    logic [1:0] e_wr_data, e_result;
    logic       e_wr_en, e_busy, e_done;
    int         op_kind;   // 0 none, 1 click, 2 clear
    int         op_k;      // edges since the op was accepted
    int         op_addr;
    logic       op_mode;
    logic [1:0] m_nv;
    int         m_a;

    function automatic bit m_in_grid(input int x, input int y, output int a);
        int dx, dy;
        dx = x;
        dy = y;
        a = (dy / 32) * 12 + (dx / 32);
        return (dx >= 0) && (dy >= 0) && (dx / 32 < 12) && (dy / 32 < 12)
            && (dx % 32 >= 2) && (dy % 32 >= 2);
    endfunction

    function automatic logic [1:0] m_update(input logic [1:0] s, input logic atk);
        if (!atk) return (s == 2'b00) ? 2'b01 : (s == 2'b01) ? 2'b00 : s;
        return (s == 2'b01) ? 2'b10 : (s == 2'b00) ? 2'b11 : s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_kind = 0; op_k = 0;
            e_rd_addr = 0; e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0;
            e_busy = 0; e_done = 0; e_result = 0;
        end else begin
            if (e_wr_en) m_grid[e_wr_addr] = e_wr_data;
            if (pre_en) m_grid[pre_addr] = pre_val;
            if (op_kind != 0) op_k++;
            if (op_kind == 1) begin
                if (op_k == 2) begin
                    m_nv = m_update(m_grid[op_addr], op_mode);
                    e_wr_en = 1; e_wr_addr = 8'(op_addr); e_wr_data = m_nv; e_result = m_nv;
                end else if (op_k == 3) begin
                    e_wr_en = 0; e_done = 1;
                end else if (op_k == 4) begin
                    e_done = 0; e_busy = 0; op_kind = 0;
                end
            end else if (op_kind == 2) begin
                if (op_k <= 144) begin
                    e_wr_en = 1; e_wr_addr = 8'(op_k - 1); e_wr_data = 2'b00;
                end else begin
                    e_wr_en = 0; e_busy = 0; op_kind = 0;
                end
            end
            if (op_kind == 0) begin
                if (click && m_in_grid(int'(mouse_xpos), int'(mouse_ypos), m_a)) begin
                    op_kind = 1; op_k = 0; op_addr = m_a; op_mode = mode;
                    e_rd_addr = 8'(m_a); e_busy = 1;
                end else if (clear_req) begin
                    op_kind = 2; op_k = 0; e_busy = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk("cyc_rd_addr", rd_addr, e_rd_addr);
        chk("cyc_wr_en",   wr_en,   e_wr_en);
        chk("cyc_wr_addr", wr_addr, e_wr_addr);
        chk("cyc_wr_data", wr_data, e_wr_data);
        chk("cyc_busy",    busy,    e_busy);
        chk("cyc_done",    done,    e_done);
        chk("cyc_result",  result,  e_result);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int x, input int y, input logic m, input logic c, input logic clr);
        @(negedge clk);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y); mode = m; click = c; clear_req = clr;
        @(negedge clk);
        click = 0; clear_req = 0;
    endtask

    task automatic preload(input int a, input logic [1:0] v);
        @(negedge clk);
        pre_en = 1; pre_addr = 8'(a); pre_val = v;
        @(negedge clk);
        pre_en = 0;
    endtask

    logic [1:0] atk_pre [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] atk_exp [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [1:0] plc_pre [3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] plc_exp [3] = '{2'b00, 2'b10, 2'b11};
    int rej_x [3] = '{1, 33, 384};
    int rej_y [3] = '{10, 10, 5};

    initial begin
        int n_wr, n_busy;
        bit found;
        click = 0; mode = 0; clear_req = 0; mouse_xpos = 0; mouse_ypos = 0;
        pre_en = 0; pre_addr = 0; pre_val = 0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", rd_addr, 0); chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // (3,3) lies left of an X_POS=10 grid
        drive(3, 3, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("off_busy", d2_busy, 0); chk("off_wr_en", d2_wr_en, 0);
            chk("off_done", d2_done, 0); chk("off_rd_addr", d2_rd_addr, 0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Place at (70,40) -> cell 14, EMPTY -> SHIP
        drive(70, 40, 0, 1, 0);
        chk("place_rd_addr", rd_addr, 14); chk("place_busy", busy, 1);
        repeat (2) @(negedge clk);
        chk("place_wr_en", wr_en, 1); chk("place_wr_addr", wr_addr, 14);
        chk("place_wr_data", wr_data, 1);
        @(negedge clk);
        chk("place_done", done, 1); chk("place_result", result, 1); chk("place_busy3", busy, 1);
        @(negedge clk);
        chk("place_idle", busy, 0); chk("place_done_end", done, 0);
        @(negedge clk);

        // Attack sweep on cell 0
        for (int i = 0; i < 4; i++) begin
            preload(0, atk_pre[i]);
            drive(5, 5, 1, 1, 0);
            repeat (2) @(negedge clk);
            chk("atk_wr_addr", wr_addr, 0); chk("atk_wr_data", wr_data, atk_exp[i]);
            @(negedge clk);
            chk("atk_result", result, atk_exp[i]);
            repeat (2) @(negedge clk);
        end

        // Placement on non-empty cells of cell 14
        for (int i = 0; i < 3; i++) begin
            preload(14, plc_pre[i]);
            drive(70, 40, 0, 1, 0);
            repeat (2) @(negedge clk);
            chk("plc_wr_data", wr_data, plc_exp[i]);
            repeat (3) @(negedge clk);
        end

        // Rejected clicks
        for (int j = 0; j < 3; j++) begin
            drive(rej_x[j], rej_y[j], 0, 1, 0);
            for (int i = 0; i < 4; i++) begin
                chk("rej_busy", busy, 0); chk("rej_wr_en", wr_en, 0);
                chk("rej_done", done, 0); chk("rej_rd_addr", rd_addr, 14);
                @(negedge clk);
            end
        end

        // Far corner
        drive(383, 383, 0, 1, 0);
        chk("corner_rd_addr", rd_addr, 143);
        repeat (2) @(negedge clk);
        chk("corner_wr_addr", wr_addr, 143);
        repeat (3) @(negedge clk);

        // Clear with a click attempted mid-sweep
        drive(0, 0, 0, 0, 1);
        mouse_xpos = 70; mouse_ypos = 40;
        n_wr = 0; n_busy = 0;
        for (int i = 0; i < 160; i++) begin
            n_wr += int'(wr_en);
            n_busy += int'(busy);
            click = (i == 40);
            @(negedge clk);
        end
        click = 0;
        chk("clear_wr_cycles", n_wr, 144); chk("clear_busy_cycles", n_busy, 145);

        // Simultaneous click and clear: only the click runs
        drive(70, 40, 0, 1, 1);
        n_wr = 0; n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            n_wr += int'(wr_en);
            n_busy += int'(busy);
            @(negedge clk);
        end
        chk("simul_wr_cycles", n_wr, 1); chk("simul_busy_cycles", n_busy, 4);

        // Reset in the middle of a clear
        drive(0, 0, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (wr_en === 1'b1 && wr_addr == 8'd60) found = 1;
            else @(negedge clk);
        end
        chk("wait_addr60", found, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0); chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_result", result, 0); chk("mid_rst_wr_data", wr_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        n_wr = 0; n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_wr += int'(wr_en);
            n_busy += int'(busy);
        end
        chk("post_rst_wr", n_wr, 0); chk("post_rst_busy", n_busy, 0);

        // Final grid contents written by the DUT versus the model
        for (int a = 0; a < 144; a++) chk("grid_cell", ram[a], m_grid[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
